// File: rtl/vslc_eeprom_writer.sv
// ---------------------------------------------------------------------------
// vslc_eeprom_writer
//
// Writes one byte into a serial (SPI) EEPROM and then polls its status
// register until the write-in-progress bit clears or the poll budget runs out.
// The SPI clock is generated outside this block; it is sampled on clk and its
// edges are found by comparing against a registered copy.
//
// Bus sequence: WREN | gap | WRITE ADDR(16b) DATA | gap | RDSR STATUS...
// copi changes on spi_clk falling edges, cipo is captured on rising edges.
//
// Ports
//   clk            system clock, all state updates on its rising edge
//   rst_n          synchronous reset, active low
//   spi_clk        externally generated SPI clock (sampled)
//   hold_n         low: freeze, spi_clk edges seen while low are lost
//   start          request a byte write (accepted only when idle)
//   address[8:0]   EEPROM byte address
//   data[7:0]      byte to write
//   cipo           serial data from the EEPROM
//   copi           serial data to the EEPROM, MSB first
//   chip_select_n  EEPROM select, active low
//   busy           high whenever a write is in progress
//   done           one-clk pulse on completion (success or timeout)
//   timeout        one-clk pulse together with done when polling ran out
//   status_byte    last complete status byte read back
// ---------------------------------------------------------------------------
module vslc_eeprom_writer #(
    parameter int unsigned POLL_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       hold_n,
    input  logic       start,
    input  logic [8:0] address,
    input  logic [7:0] data,
    input  logic       cipo,
    output logic       copi,
    output logic       chip_select_n,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] status_byte
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP1,
        S_WRITE,
        S_ADDR,
        S_DATA,
        S_GAP2,
        S_RDSR,
        S_STATUS
    } state_t;

    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    // Poll counter value of the last status byte we are allowed to read.
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  status_q, status_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        spi_clk_q;

    logic        spi_rise;
    logic        spi_fall;
    logic [15:0] addr_word;

    // Edges are qualified by hold_n; the history register keeps tracking
    // spi_clk during a hold so an edge lost while frozen is never replayed.
    assign spi_rise  = hold_n &  spi_clk & ~spi_clk_q;
    assign spi_fall  = hold_n & ~spi_clk &  spi_clk_q;
    assign addr_word = {7'b0, addr_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            poll_cnt_q <= 8'd0;
            shift_q    <= 8'd0;
            status_q   <= 8'd0;
            addr_q     <= 9'd0;
            data_q     <= 8'd0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            spi_clk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            shift_q    <= shift_d;
            status_q   <= status_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            spi_clk_q  <= spi_clk;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        poll_cnt_d = poll_cnt_q;
        shift_d    = shift_q;
        status_d   = status_q;
        addr_d     = addr_q;
        data_d     = data_q;
        // done/timeout are single-cycle pulses, so they drop every clk.
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        if (hold_n) begin
            if (state_q == S_STATUS && spi_rise) begin
                shift_d = {shift_q[6:0], cipo};
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d     = address;
                        data_d     = data;
                        poll_cnt_d = 8'd0;
                        bit_cnt_d  = 4'd7;
                        state_d    = S_WREN;
                    end
                end
                S_GAP1: begin
                    if (spi_fall) begin
                        bit_cnt_d = 4'd7;
                        state_d   = S_WRITE;
                    end
                end
                S_GAP2: begin
                    if (spi_fall) begin
                        bit_cnt_d = 4'd7;
                        state_d   = S_RDSR;
                    end
                end
                S_STATUS: begin
                    if (spi_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            // shift_q already holds all 8 bits: the last
                            // rising edge came before this falling edge.
                            status_d = shift_q;
                            if (!shift_q[0]) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else if (poll_cnt_q == POLL_LAST) begin
                                state_d   = S_IDLE;
                                done_d    = 1'b1;
                                timeout_d = 1'b1;
                            end else begin
                                poll_cnt_d = poll_cnt_q + 8'd1;
                                bit_cnt_d  = 4'd7;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    // Shifting states: WREN, WRITE, ADDR, DATA, RDSR.
                    if (spi_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            case (state_q)
                                S_WREN: begin
                                    state_d   = S_GAP1;
                                    bit_cnt_d = 4'd0;
                                end
                                S_WRITE: begin
                                    state_d   = S_ADDR;
                                    bit_cnt_d = 4'd15;
                                end
                                S_ADDR: begin
                                    state_d   = S_DATA;
                                    bit_cnt_d = 4'd7;
                                end
                                S_DATA: begin
                                    state_d   = S_GAP2;
                                    bit_cnt_d = 4'd0;
                                end
                                S_RDSR: begin
                                    state_d   = S_STATUS;
                                    bit_cnt_d = 4'd7;
                                end
                                default: begin
                                    state_d   = S_IDLE;
                                    bit_cnt_d = 4'd0;
                                end
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        copi = 1'b0;
        case (state_q)
            S_WREN:  copi = CMD_WREN[bit_cnt_q[2:0]];
            S_WRITE: copi = CMD_WRITE[bit_cnt_q[2:0]];
            S_ADDR:  copi = addr_word[bit_cnt_q];
            S_DATA:  copi = data_q[bit_cnt_q[2:0]];
            S_RDSR:  copi = CMD_RDSR[bit_cnt_q[2:0]];
            default: copi = 1'b0;
        endcase
    end

    // CS is released only between commands; consecutive status reads stay
    // inside one select period.
    assign chip_select_n = (state_q == S_IDLE) || (state_q == S_GAP1) || (state_q == S_GAP2);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign status_byte   = status_q;

endmodule
